// File: rtl/booth4_pp_gen_seq_if.sv
// Operand input and serial partial-product output bundle for booth4_pp_gen_seq.
// The slave side is the generator; the master side feeds operands and drains digits.
interface booth4_pp_gen_seq_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               pp_valid;
  logic               pp_ready;
  logic [WIDTH+1:0]   pp_data;
  logic [IDX_W-1:0]   pp_idx;
  logic               pp_last;

  modport slave (
    input  in_valid, in_a, in_b, pp_ready,
    output in_ready, pp_valid, pp_data, pp_idx, pp_last
  );

  modport master (
    output in_valid, in_a, in_b, pp_ready,
    input  in_ready, pp_valid, pp_data, pp_idx, pp_last
  );
endinterface

// File: rtl/booth4_pp_gen_seq.sv
// Serial radix-4 Booth partial products d_i*A, LSB digit first; first beat 2 cycles after accept, outputs hold while pp_ready is low.
// Optional BOOTH4_INV_SIGN_EN: pp_data MSB carries the inverted sign bit for compressor-tree sign extension.
module booth4_pp_gen_seq #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  booth4_pp_gen_seq_if.slave    io,
  output logic                  busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {IDLE, PREP, EMIT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH:0]     na_q, na_c, na_sel;
  logic [WIDTH:0]     b_ext;
  logic [2:0]         trip;
  logic [WIDTH+1:0]   pp_data_q, pp_sel;
  logic [IDX_W-1:0]   pp_idx_q, dig_idx;
  logic               pp_valid_q, pp_last_q;
  logic               accept, load_pp, finish;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load_pp = 1'b0;
    finish  = 1'b0;
    dig_idx = pp_idx_q + IDX_W'(1);
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          accept  = 1'b1;
          state_d = PREP;
        end
      end
      PREP: begin
        load_pp = 1'b1;
        dig_idx = '0;
        state_d = EMIT;
      end
      EMIT: begin
        if (io.pp_ready) begin
          if (pp_last_q) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            load_pp = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -A is not registered yet while digit 0 is being formed in PREP, so use it combinationally there.
  always_comb begin
    na_c   = -{a_q[WIDTH-1], a_q};
    na_sel = (state_q == PREP) ? na_c : na_q;
    b_ext  = {b_q, 1'b0};
    trip   = 3'(b_ext >> {dig_idx, 1'b0});
    pp_sel = '0;
    case (trip)
      3'b001, 3'b010: pp_sel = {a_q[WIDTH-1], a_q[WIDTH-1], a_q};
      3'b011:         pp_sel = {a_q[WIDTH-1], a_q, 1'b0};
      3'b100:         pp_sel = {na_sel, 1'b0};
      3'b101, 3'b110: pp_sel = {na_sel[WIDTH], na_sel};
      default:        pp_sel = '0;
    endcase
`ifdef BOOTH4_INV_SIGN_EN
    pp_sel[WIDTH+1] = ~pp_sel[WIDTH+1];
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      a_q        <= '0;
      b_q        <= '0;
      na_q       <= '0;
      pp_data_q  <= '0;
      pp_idx_q   <= '0;
      pp_last_q  <= 1'b0;
      pp_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= io.in_a;
        b_q <= io.in_b;
      end
      if (state_q == PREP) na_q <= na_c;
      if (load_pp) begin
        pp_data_q  <= pp_sel;
        pp_idx_q   <= dig_idx;
        pp_last_q  <= (dig_idx == LAST_IDX);
        pp_valid_q <= 1'b1;
      end else if (finish) begin
        pp_valid_q <= 1'b0;
      end
    end
  end

  assign io.in_ready = (state_q == IDLE);
  assign io.pp_valid = pp_valid_q;
  assign io.pp_data  = pp_data_q;
  assign io.pp_idx   = pp_idx_q;
  assign io.pp_last  = pp_last_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_booth4_pp_gen_seq.sv
// Bench for booth4_pp_gen_seq (WIDTH=16): vector table, backpressure, busy guard, mid-transaction reset, random pairs.
module tb_booth4_pp_gen_seq;

`ifdef BOOTH4_INV_SIGN_EN
  localparam logic [17:0] INV_M = 18'h20000;
`else
  localparam logic [17:0] INV_M = 18'h00000;
`endif

  typedef struct packed {
    logic [15:0]        a;
    logic [15:0]        b;
    logic [1:0]         mode;
    logic [7:0][17:0]   exp;
  } vec_t;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic busy;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl [8];

  always #5 sys_clk = ~sys_clk;

  booth4_pp_gen_seq_if #(.WIDTH(16), .IDX_W(4)) io ();

  booth4_pp_gen_seq #(.WIDTH(16), .IDX_W(4)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .io      (io),
    .busy    (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Digit value straight from the recoding rule: d = -2*b[2i+1] + b[2i] + b[2i-1].
  function automatic logic [17:0] ref_pp(input logic [15:0] a, input logic [15:0] b, input int i);
    logic [16:0] bx;
    longint      d, p;
    logic [17:0] r;
    bx = {b, 1'b0};
    d  = -2 * longint'(bx[2*i+2]) + longint'(bx[2*i+1]) + longint'(bx[2*i]);
    p  = d * longint'($signed(a));
    r  = p[17:0];
    return r ^ INV_M;
  endfunction

  function automatic logic [7:0][17:0] ref_all(input logic [15:0] a, input logic [15:0] b);
    logic [7:0][17:0] e;
    for (int i = 0; i < 8; i++) e[i] = ref_pp(a, b, i);
    return e;
  endfunction

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic [7:0][17:0] exp,
                         input logic [1:0] mode, input bit guard, input logic [15:0] ga, input logic [15:0] gb);
    int          cnt, cyc, k;
    bit          done, stalled, rdy;
    logic [17:0] p_dat, v;
    logic [3:0]  p_idx;
    logic        p_last;
    longint      sum;
    cnt = 0; cyc = 0; k = 0; done = 0; stalled = 0; sum = 0;
    p_dat = '0; p_idx = '0; p_last = 1'b0;
    @(negedge sys_clk);
    chk("idle_in_ready", 64'(io.in_ready), 64'd1);
    io.in_valid = 1'b1;
    io.in_a     = a;
    io.in_b     = b;
    io.pp_ready = 1'b1;
    @(negedge sys_clk);
    if (guard) begin
      io.in_a = ga;
      io.in_b = gb;
    end else begin
      io.in_valid = 1'b0;
    end
    chk("prep_pp_valid", 64'(io.pp_valid), 64'd0);
    chk("prep_busy", 64'(busy), 64'd1);
    chk("prep_in_ready", 64'(io.in_ready), 64'd0);
    while (!done) begin
      @(negedge sys_clk);
      cyc++;
      if (cyc > 100) begin
        n_vec++; n_err++;
        $display("FAIL txn_timeout: got %0d beats, expected 8", cnt);
        break;
      end
      if (cyc == 1) chk("first_beat_latency", 64'(io.pp_valid), 64'd1);
      if (stalled) begin
        chk("stall_data", 64'(io.pp_data), 64'(p_dat));
        chk("stall_idx", 64'(io.pp_idx), 64'(p_idx));
        chk("stall_last", 64'(io.pp_last), 64'(p_last));
      end
      case (mode)
        2'd1:    rdy = (k % 4 == 0) || (k % 4 == 3);
        2'd2:    rdy = ($urandom_range(0, 1) == 1);
        default: rdy = 1'b1;
      endcase
      io.pp_ready = rdy;
      if (io.pp_valid) begin
        k++;
        if (rdy) begin
          chk("beat_data", 64'(io.pp_data), 64'(exp[cnt[2:0]]));
          chk("beat_idx", 64'(io.pp_idx), 64'(cnt));
          chk("beat_last", 64'(io.pp_last), 64'(cnt == 7));
          chk("beat_in_ready", 64'(io.in_ready), 64'd0);
          v   = io.pp_data ^ INV_M;
          sum += longint'($signed(v)) * (longint'(1) <<< (2 * cnt));
          cnt++;
          if (io.pp_last || cnt > 8) done = 1;
        end
        stalled = !rdy;
        p_dat   = io.pp_data;
        p_idx   = io.pp_idx;
        p_last  = io.pp_last;
      end
    end
    @(negedge sys_clk);
    io.in_valid = 1'b0;
    io.pp_ready = 1'b0;
    chk("end_pp_valid", 64'(io.pp_valid), 64'd0);
    chk("end_in_ready", 64'(io.in_ready), 64'd1);
    chk("end_busy", 64'(busy), 64'd0);
    chk("beat_count", 64'(cnt), 64'd8);
    chk("weighted_sum", 64'(sum), 64'(longint'($signed(a)) * longint'($signed(b))));
  endtask

  initial begin
    int cyc;
    logic [15:0] ra, rb;
    io.in_valid = 1'b0;
    io.in_a     = '0;
    io.in_b     = '0;
    io.pp_ready = 1'b0;
    sys_rst     = 1'b1;

    for (int i = 0; i < 8; i++) tbl[i] = '0;
    tbl[0].a = 16'd3;    tbl[0].b = 16'd7;    tbl[0].exp[0] = 18'h3FFFD; tbl[0].exp[1] = 18'h00006;
    tbl[1].a = 16'h8000; tbl[1].b = 16'h8000; tbl[1].exp[7] = 18'h10000;
    tbl[2].a = 16'd1;    tbl[2].b = 16'd1;    tbl[2].exp[0] = 18'h00001;
    tbl[3].a = 16'h7FFF; tbl[3].b = 16'hFFFF; tbl[3].exp[0] = 18'h38001;
    tbl[4].a = 16'd5;    tbl[4].b = 16'd2;    tbl[4].exp[0] = 18'h3FFF6; tbl[4].exp[1] = 18'h00005;
    tbl[5].a = 16'hFFFE; tbl[5].b = 16'd3;    tbl[5].exp[0] = 18'h00002; tbl[5].exp[1] = 18'h3FFFE;
    tbl[6] = tbl[0]; tbl[6].mode = 2'd1;
    tbl[7] = tbl[4]; tbl[7].mode = 2'd2;

    repeat (3) @(negedge sys_clk);
    chk("rst_in_ready", 64'(io.in_ready), 64'd1);
    chk("rst_pp_valid", 64'(io.pp_valid), 64'd0);
    chk("rst_pp_data", 64'(io.pp_data), 64'd0);
    chk("rst_pp_idx", 64'(io.pp_idx), 64'd0);
    chk("rst_pp_last", 64'(io.pp_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    sys_rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].a, tbl[i].b, tbl[i].exp ^ {8{INV_M}}, tbl[i].mode, 1'b0, '0, '0);

    // New operands held on in_valid during EMIT must wait for the pp_last handshake.
    run_txn(16'd3, 16'd7, tbl[0].exp ^ {8{INV_M}}, 2'd0, 1'b1, 16'h1234, 16'h5678);
    run_txn(16'h1234, 16'h5678, ref_all(16'h1234, 16'h5678), 2'd0, 1'b0, '0, '0);

    // Reset while idx3 is on the output.
    @(negedge sys_clk);
    io.in_valid = 1'b1; io.in_a = 16'd3; io.in_b = 16'd7; io.pp_ready = 1'b1;
    @(negedge sys_clk);
    io.in_valid = 1'b0;
    cyc = 0;
    while (!(io.pp_valid && io.pp_idx == 4'd3) && cyc < 50) begin
      @(negedge sys_clk);
      cyc++;
    end
    chk("midrst_reach_idx3", 64'(io.pp_idx), 64'd3);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    io.pp_ready = 1'b0;
    chk("midrst_pp_valid", 64'(io.pp_valid), 64'd0);
    chk("midrst_in_ready", 64'(io.in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_pp_data", 64'(io.pp_data), 64'd0);
    chk("midrst_pp_idx", 64'(io.pp_idx), 64'd0);
    run_txn(16'd1, 16'd1, tbl[2].exp ^ {8{INV_M}}, 2'd0, 1'b0, '0, '0);

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 0) ra = 16'h8000;
      if (i == 1) rb = 16'hAAAA;
      run_txn(ra, rb, ref_all(ra, rb), 2'd2, 1'b0, '0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
